// File: rtl/countdown_timer_if.sv
// Control and status bundle for the minutes:seconds countdown timer.
// The master side drives the tick and control pulses. The slave side is the timer.
interface countdown_timer_if;
  logic        e;
  logic        load;
  logic [11:0] preset;
  logic        start;
  logic        stop;
  logic [11:0] count;
  logic        running;
  logic        done;
  logic        expire;

  modport master (
    output e, load, preset, start, stop,
    input  count, running, done, expire
  );

  modport slave (
    input  e, load, preset, start, stop,
    output count, running, done, expire
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable minutes:seconds countdown timer.
// The count is packed as {1'b0, min[3:0], sec[6:0]}.
// The timer decrements on each tick e while running.
// It pulses expire when the count reaches 0:00.
module countdown_timer #(
  parameter int MAX_SEC     = 59,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  countdown_timer_if.slave bus
);

  localparam logic [6:0] MAX_SEC_V = 7'(MAX_SEC);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [11:0] preset_q, preset_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        expire_q, expire_d;
  logic [3:0]  min_nx;
  logic [6:0]  sec_nx;

  // Bit 11 of the preset carries no information.
  logic unused_preset_msb;
  assign unused_preset_msb = bus.preset[11];

  // Clamp an out-of-range seconds field to the largest legal value.
  function automatic logic [6:0] sat_sec(input logic [6:0] s);
    return (s > MAX_SEC_V) ? MAX_SEC_V : s;
  endfunction

  // Next-state logic. The priority order is load, then stop, then start, then tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    expire_d = 1'b0;
    min_nx   = count_q[10:7];
    sec_nx   = count_q[6:0];
    if (bus.load) begin
      preset_d = {1'b0, bus.preset[10:7], sat_sec(bus.preset[6:0])};
      count_d  = preset_d;
      state_d  = IDLE;
    end else if (bus.stop) begin
      // stop also masks a simultaneous start in every state
      if (state_q == RUN) state_d = PAUSE;
    end else if (bus.start && (state_q == IDLE || state_q == PAUSE)) begin
      if (count_q[10:0] != 11'd0) state_d = RUN;
    end else if (bus.e && state_q == RUN) begin
      if (count_q[10:0] == 11'd0) begin
        // Only reachable with auto-reload: this tick restores the preset
        count_d = preset_q;
        if (preset_q[10:0] == 11'd0) state_d = DONE;
      end else begin
        if (sec_nx != 7'd0) begin
          sec_nx = sec_nx - 7'd1;
        end else begin
          sec_nx = MAX_SEC_V;
          min_nx = min_nx - 4'd1;
        end
        count_d = {1'b0, min_nx, sec_nx};
        if ({min_nx, sec_nx} == 11'd0) begin
          expire_d = 1'b1;
          if (!AUTO_RELOAD || preset_q[10:0] == 11'd0) state_d = DONE;
        end
      end
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= 12'd0;
      preset_q  <= 12'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      preset_q  <= preset_d;
      running_q <= running_d;
      done_q    <= done_d;
      expire_q  <= expire_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expire  = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer.
// Two instances are driven with identical stimulus: one without auto-reload and one with it.
// Each instance is compared cycle by cycle against a model that tracks total seconds.
module tb_countdown_timer;

  localparam int RADIX   = 60;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  countdown_timer_if bus0();
  countdown_timer_if bus1();

  countdown_timer #(.MAX_SEC(59), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  countdown_timer #(.MAX_SEC(59), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance. Index 0 is without auto-reload, index 1 is with it.
  int m_t[2];
  int m_p[2];
  int m_mode[2];
  bit m_exp[2];

  function automatic logic [11:0] enc(input int t);
    logic [11:0] v;
    v = {1'b0, 4'(t / RADIX), 7'(t % RADIX)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_p[k] = 0; m_mode[k] = M_IDLE; m_exp[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit e, input bit ld, input logic [11:0] p,
                            input bit st, input bit sp);
    int sec;
    m_exp[k] = 1'b0;
    if (ld) begin
      sec = (int'(p[6:0]) > 59) ? 59 : int'(p[6:0]);
      m_p[k] = int'(p[10:7]) * RADIX + sec;
      m_t[k] = m_p[k];
      m_mode[k] = M_IDLE;
    end else if (sp) begin
      if (m_mode[k] == M_RUN) m_mode[k] = M_PAUSE;
    end else if (st && (m_mode[k] == M_IDLE || m_mode[k] == M_PAUSE)) begin
      if (m_t[k] != 0) m_mode[k] = M_RUN;
    end else if (e && m_mode[k] == M_RUN) begin
      if (m_t[k] == 0) begin
        m_t[k] = m_p[k];
        if (m_p[k] == 0) m_mode[k] = M_DONE;
      end else begin
        m_t[k] = m_t[k] - 1;
        if (m_t[k] == 0) begin
          m_exp[k] = 1'b1;
          if (k == 0 || m_p[k] == 0) m_mode[k] = M_DONE;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("count0",   32'(bus0.count),   32'(enc(m_t[0])));
    chk("running0", 32'(bus0.running), 32'(m_mode[0] == M_RUN));
    chk("done0",    32'(bus0.done),    32'(m_mode[0] == M_DONE));
    chk("expire0",  32'(bus0.expire),  32'(m_exp[0]));
    chk("count1",   32'(bus1.count),   32'(enc(m_t[1])));
    chk("running1", 32'(bus1.running), 32'(m_mode[1] == M_RUN));
    chk("done1",    32'(bus1.done),    32'(m_mode[1] == M_DONE));
    chk("expire1",  32'(bus1.expire),  32'(m_exp[1]));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input bit e, input bit ld, input logic [11:0] p, input bit st, input bit sp);
    bus0.e = e; bus0.load = ld; bus0.preset = p; bus0.start = st; bus0.stop = sp;
    bus1.e = e; bus1.load = ld; bus1.preset = p; bus1.start = st; bus1.stop = sp;
    @(posedge clk);
    model_step(0, e, ld, p, st, sp);
    model_step(1, e, ld, p, st, sp);
    #1;
    check_all();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] rp;
    rst = 1'b0;
    step_inputs_idle();
    model_reset();
    #12;
    chk("rst_count",   32'(bus0.count),   32'h000);
    chk("rst_running", 32'(bus0.running), 32'h0);
    chk("rst_done",    32'(bus0.done),    32'h0);
    chk("rst_expire",  32'(bus0.expire),  32'h0);
    rst = 1'b1;

    // Reset in the middle of a countdown acts without a clock edge
    step(1'b0, 1'b1, 12'h0A5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(3);
    chk("t1_pre_rst", 32'(bus0.count), 32'h0A2);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_count",   32'(bus0.count),   32'h000);
    chk("t1_rst_running", 32'(bus0.running), 32'h0);
    chk("t1_rst_done",    32'(bus0.done),    32'h0);
    model_reset();
    #2 rst = 1'b1;

    // Borrow from minutes
    step(1'b0, 1'b1, 12'h100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(1);
    chk("t2_borrow", 32'(bus0.count), 32'h0BB);
    tick(59);
    chk("t2_1m00", 32'(bus0.count), 32'h080);

    // Expiry without reload
    step(1'b0, 1'b1, 12'h003, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(3);
    chk("t3_count",   32'(bus0.count),   32'h000);
    chk("t3_expire",  32'(bus0.expire),  32'h1);
    chk("t3_done",    32'(bus0.done),    32'h1);
    chk("t3_running", 32'(bus0.running), 32'h0);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("t3_expire_gone", 32'(bus0.expire), 32'h0);
    tick(1);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    chk("t3_stays0", 32'(bus0.count), 32'h000);
    chk("t3_stays_done", 32'(bus0.done), 32'h1);

    // Pause and resume, with stop winning over start
    step(1'b0, 1'b1, 12'h00A, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(2);
    chk("t4_count8", 32'(bus0.count), 32'h008);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    chk("t4_paused", 32'(bus0.running), 32'h0);
    tick(5);
    chk("t4_hold", 32'(bus0.count), 32'h008);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(1);
    chk("t4_resume", 32'(bus0.count), 32'h007);

    // Seconds saturation and load beating a tick
    step(1'b0, 1'b1, 12'h07F, 1'b0, 1'b0);
    chk("t5_sat", 32'(bus0.count), 32'h03B);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 12'h07F, 1'b0, 1'b0);
    chk("t5_load_wins", 32'(bus0.count), 32'h03B);
    chk("t5_idle", 32'(bus0.running), 32'h0);

    // Auto-reload instance
    step(1'b0, 1'b1, 12'h002, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    tick(2);
    chk("t6_zero",    32'(bus1.count),   32'h000);
    chk("t6_expire",  32'(bus1.expire),  32'h1);
    chk("t6_running", 32'(bus1.running), 32'h1);
    tick(1);
    chk("t6_reload", 32'(bus1.count), 32'h002);
    chk("t6_noexp",  32'(bus1.expire), 32'h0);
    tick(2);
    chk("t6_expire2", 32'(bus1.expire), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rp = {1'($urandom), 4'($urandom_range(0, 2)), 7'($urandom_range(0, 127))};
      if ($urandom_range(0, 19) == 0) rp[10:7] = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), rp,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic step_inputs_idle();
    bus0.e = 1'b0; bus0.load = 1'b0; bus0.preset = 12'h000; bus0.start = 1'b0; bus0.stop = 1'b0;
    bus1.e = 1'b0; bus1.load = 1'b0; bus1.preset = 12'h000; bus1.start = 1'b0; bus1.stop = 1'b0;
  endtask

endmodule
